// File: rtl/clock_pkg.sv
// clock_pkg: BCD time types, entry FSM states, field limits and the time-validity check.
package clock_pkg;
  typedef logic [3:0]  bcd_digit_t;
  typedef logic [15:0] bcd_time_t;
  typedef enum logic {IDLE, ENTRY} entry_state_t;
  localparam bcd_digit_t MAX_H10    = 4'd2;
  localparam logic [7:0] MAX_H_23   = 8'h23;
  localparam bcd_digit_t MAX_M10    = 4'd5;
  localparam int         MAX_DIGITS = 4;
  // Packed BCD compares in digit order, so HH <= 8'h23 is a plain magnitude test.
  function automatic logic valid_time(bcd_time_t t);
    return (t[15:12] <= MAX_H10) && (t[11:8] <= 4'd9) && (t[15:8] <= MAX_H_23) &&
           (t[7:4] <= MAX_M10) && (t[3:0] <= 4'd9);
  endfunction
endpackage

// File: rtl/alarm_time_source_if.sv
// alarm_time_source_if: keypad/control inputs and time/display outputs of the alarm time source.
interface alarm_time_source_if;
  import clock_pkg::*;
  logic [3:0] key;
  logic       key_valid;
  logic       load_time;
  logic       load_alarm;
  logic       show_alarm;
  logic       fast_watch;
  bcd_time_t  current_time;
  bcd_time_t  alarm_time;
  logic       show_a;
  logic       entry_active;
  bcd_time_t  entry_buf;
  modport master (
    output key, key_valid, load_time, load_alarm, show_alarm, fast_watch,
    input  current_time, alarm_time, show_a, entry_active, entry_buf
  );
  modport slave (
    input  key, key_valid, load_time, load_alarm, show_alarm, fast_watch,
    output current_time, alarm_time, show_a, entry_active, entry_buf
  );
endinterface

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: HHMM BCD time of day; a load always beats a same-cycle increment.
module bcd_time_counter import clock_pkg::*; (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      inc_i,
  input  logic      load_i,
  input  bcd_time_t load_value_i,
  output bcd_time_t time_o
);
  bcd_time_t time_q, time_d;
  logic m_wrap, h_wrap;
  assign m_wrap = time_q[7:0] == 8'h59;
  assign h_wrap = time_q[15:8] == MAX_H_23;
  always_comb begin
    time_d = time_q;
    if (load_i) time_d = load_value_i;
    else if (inc_i) begin
      time_d[3:0] = (time_q[3:0] == 4'd9) ? 4'd0 : time_q[3:0] + 4'd1;
      if (time_q[3:0] == 4'd9) time_d[7:4] = m_wrap ? 4'd0 : time_q[7:4] + 4'd1;
      if (m_wrap) time_d[15:8] = h_wrap ? 8'h00 :
                                 (time_q[11:8] == 4'd9) ? {time_q[15:12] + 4'd1, 4'd0} :
                                                          {time_q[15:12], time_q[11:8] + 4'd1};
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) time_q <= '0;
    else          time_q <= time_d;
  assign time_o = time_q;
endmodule

// File: rtl/alarm_time_source.sv
// alarm_time_source: running time of day, stored alarm time and keypad digit entry
// feeding the comparator/display mux.
module alarm_time_source import clock_pkg::*; #(
  parameter int CLK_PER_SEC   = 256,
  parameter int SEC_PER_MIN   = 60,
  parameter int ENTRY_TIMEOUT = 10
) (
  input logic                clock,
  input logic                reset_n,
  alarm_time_source_if.slave bus
);
  localparam int PW = $clog2(CLK_PER_SEC);
  localparam int SW = $clog2(SEC_PER_MIN);
  localparam int TW = $clog2(ENTRY_TIMEOUT + 1);
  entry_state_t  state_q, state_d;
  bcd_time_t     buf_q, buf_d, alarm_q, alarm_d, time_w;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          show_q;
  logic in_entry, sec_tick, min_tick, digit_ok, ld_any, commit_ok, commit_time, key_acc, timeout;
  assign in_entry    = state_q == ENTRY;
  assign sec_tick    = presc_q == PW'(CLK_PER_SEC - 1);
  assign min_tick    = sec_tick & (bus.fast_watch | (sec_q == SW'(SEC_PER_MIN - 1)));
  assign digit_ok    = bus.key_valid & (bus.key <= 4'd9);
  assign ld_any      = in_entry & (bus.load_time | bus.load_alarm);
  assign commit_ok   = in_entry & (bus.load_time ^ bus.load_alarm) &
                       (cnt_q == 3'(MAX_DIGITS)) & valid_time(buf_q);
  assign commit_time = commit_ok & bus.load_time;
  // A load strobe in ENTRY always ends the entry, so it shadows any same-cycle key.
  assign key_acc     = in_entry & ~ld_any & digit_ok & (cnt_q < 3'(MAX_DIGITS));
  assign timeout     = in_entry & ~ld_any & ~key_acc & sec_tick & (to_q == TW'(ENTRY_TIMEOUT - 1));
  always_comb begin
    presc_d = (commit_time | sec_tick) ? '0 : presc_q + PW'(1);
    sec_d   = (commit_time | bus.fast_watch | min_tick) ? '0 : sec_q + SW'(sec_tick);
    alarm_d = (commit_ok & bus.load_alarm) ? buf_q : alarm_q;
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    if (!in_entry && digit_ok) begin
      state_d = ENTRY;
      buf_d   = {12'h000, bus.key};
      cnt_d   = 3'd1;
      to_d    = '0;
    end else if (ld_any | timeout) begin
      state_d = IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      to_d    = '0;
    end else if (key_acc) begin
      buf_d = {buf_q[11:0], bus.key};
      cnt_d = cnt_q + 3'd1;
      to_d  = '0;
    end else if (in_entry && sec_tick) to_d = to_q + TW'(1);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      presc_q <= '0;
      sec_q   <= '0;
      alarm_q <= '0;
      show_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      alarm_q <= alarm_d;
      show_q  <= bus.show_alarm & ~in_entry;
    end
  bcd_time_counter u_time (
    .clock        (clock),
    .reset_n      (reset_n),
    .inc_i        (min_tick),
    .load_i       (commit_time),
    .load_value_i (buf_q),
    .time_o       (time_w)
  );
  assign bus.current_time = time_w;
  assign bus.alarm_time   = alarm_q;
  assign bus.show_a       = show_q;
  assign bus.entry_active = in_entry;
  assign bus.entry_buf    = buf_q;
endmodule

// File: tb/tb_alarm_time_source.sv
// tb_alarm_time_source: directed test-plan sequence plus random stimulus, checked every cycle
// against a minutes-of-day / digit-queue model of the alarm time source.
module tb_alarm_time_source;
  localparam int CPS = 256;
  localparam int SPM = 60;
  localparam int ETO = 10;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  alarm_time_source_if bus();
  alarm_time_source #(.CLK_PER_SEC(CPS), .SEC_PER_MIN(SPM), .ENTRY_TIMEOUT(ETO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int pc, sc, tmin, amin, to_cnt, ent, show;
  int digs[$];

  function automatic logic [15:0] to_bcd(int t);
    int h, m;
    h = t / 60;
    m = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] buf_val();
    int v = 0;
    foreach (digs[i]) v = v * 16 + digs[i];
    return 16'(v);
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pc = 0; sc = 0; tmin = 0; amin = 0; to_cnt = 0; ent = 0; show = 0;
    digs.delete();
  endtask

  task automatic model_step();
    bit st, mt, lt, la, kd, ok;
    int h, m;
    if (!reset_n) begin
      model_reset();
      return;
    end
    st = pc == CPS - 1;
    mt = st && (bus.fast_watch || sc == SPM - 1);
    lt = bus.load_time;
    la = bus.load_alarm;
    kd = bus.key_valid && bus.key <= 9;
    ok = 0; h = 0; m = 0;
    if (ent != 0 && digs.size() == 4) begin
      h = digs[0] * 10 + digs[1];
      m = digs[2] * 10 + digs[3];
      ok = (lt ^ la) && h < 24 && digs[2] <= 5;
    end
    show = (bus.show_alarm && ent == 0) ? 1 : 0;
    if (ok && la) amin = h * 60 + m;
    if (ok && lt) begin
      tmin = h * 60 + m; pc = 0; sc = 0;
    end else begin
      if (mt) tmin = (tmin + 1) % 1440;
      sc = (bus.fast_watch || mt) ? 0 : sc + (st ? 1 : 0);
      pc = st ? 0 : pc + 1;
    end
    if (ent == 0) begin
      if (kd) begin
        ent = 1; digs.delete(); digs.push_back(int'(bus.key)); to_cnt = 0;
      end
    end else if (lt || la) begin
      ent = 0; digs.delete(); to_cnt = 0;
    end else if (kd && digs.size() < 4) begin
      digs.push_back(int'(bus.key)); to_cnt = 0;
    end else if (st) begin
      to_cnt++;
      if (to_cnt == ETO) begin
        ent = 0; digs.delete(); to_cnt = 0;
      end
    end
  endtask

  always @(negedge clock) if (chk_en) begin
    chk("current_time", bus.current_time, to_bcd(tmin));
    chk("alarm_time", bus.alarm_time, to_bcd(amin));
    chk("show_a", 16'(bus.show_a), 16'(show));
    chk("entry_active", 16'(bus.entry_active), 16'(ent));
    chk("entry_buf", bus.entry_buf, buf_val());
  end

  task automatic cyc();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic press(int d);
    bus.key = 4'(d);
    bus.key_valid = 1'b1;
    cyc();
    bus.key_valid = 1'b0;
  endtask

  task automatic load(bit t, bit a);
    bus.load_time = t;
    bus.load_alarm = a;
    cyc();
    bus.load_time = 1'b0;
    bus.load_alarm = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key = '0; bus.key_valid = 0; bus.load_time = 0; bus.load_alarm = 0;
    bus.show_alarm = 0; bus.fast_watch = 1;
    model_reset();
    #1 reset_n = 1'b0;
    chk_en = 1;
    @(negedge clock);
    @(negedge clock);
    chk("rst current_time", bus.current_time, 16'h0000);
    chk("rst alarm_time", bus.alarm_time, 16'h0000);
    chk("rst entry_active", 16'(bus.entry_active), 16'h0);
    chk("rst show_a", 16'(bus.show_a), 16'h0);
    chk("rst entry_buf", bus.entry_buf, 16'h0000);
    reset_n = 1'b1;
    run(60 * CPS);
    chk("fast 60 ticks", bus.current_time, 16'h0100);
    bus.fast_watch = 0;
    run(60 * CPS);
    chk("normal one minute", bus.current_time, 16'h0101);
    press(2); press(3); press(5); press(8);
    load(1, 0);
    chk("load 2358", bus.current_time, 16'h2358);
    chk("entry ends after load", 16'(bus.entry_active), 16'h0);
    bus.fast_watch = 1;
    run(CPS);
    chk("advance 2359", bus.current_time, 16'h2359);
    run(CPS);
    chk("wrap 0000", bus.current_time, 16'h0000);
    bus.fast_watch = 0;
    press(0); press(7); press(3); press(0);
    load(0, 1);
    chk("alarm 0730", bus.alarm_time, 16'h0730);
    chk("time kept on alarm load", bus.current_time, 16'h0000);
    press(2); press(4); press(0); press(0);
    load(0, 1);
    chk("alarm 2400 rejected", bus.alarm_time, 16'h0730);
    chk("buf cleared on reject", bus.entry_buf, 16'h0000);
    press(1); press(2);
    load(1, 0);
    chk("short entry rejected", bus.current_time, 16'h0000);
    chk("short entry idle", 16'(bus.entry_active), 16'h0);
    press(1); press(2); press(3); press(4);
    load(1, 1);
    chk("double load time", bus.current_time, 16'h0000);
    chk("double load alarm", bus.alarm_time, 16'h0730);
    chk("double load idle", 16'(bus.entry_active), 16'h0);
    press(4);
    chk("entry starts", 16'(bus.entry_active), 16'h1);
    chk("entry buf 0004", bus.entry_buf, 16'h0004);
    run(9 * CPS);
    chk("still in entry at 9 s", 16'(bus.entry_active), 16'h1);
    run(CPS);
    chk("timeout exits", 16'(bus.entry_active), 16'h0);
    chk("timeout clears buf", bus.entry_buf, 16'h0000);
    press(11);
    chk("key B ignored", 16'(bus.entry_active), 16'h0);
    bus.show_alarm = 1;
    cyc();
    chk("show_a follows", 16'(bus.show_a), 16'h1);
    press(5);
    chk("entry with show", 16'(bus.entry_active), 16'h1);
    cyc();
    chk("show_a masked", 16'(bus.show_a), 16'h0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async rst time", bus.current_time, 16'h0000);
    chk("async rst alarm", bus.alarm_time, 16'h0000);
    chk("async rst entry", 16'(bus.entry_active), 16'h0);
    chk("async rst buf", bus.entry_buf, 16'h0000);
    chk("async rst show", 16'(bus.show_a), 16'h0);
    bus.show_alarm = 0;
    @(negedge clock);
    reset_n = 1'b1;
    bus.fast_watch = 1;
    repeat (8000) begin
      bus.key_valid  = $urandom_range(0, 1) == 0;
      bus.key        = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      bus.load_time  = $urandom_range(0, 15) == 0;
      bus.load_alarm = $urandom_range(0, 15) == 0;
      bus.show_alarm = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 499) == 0) bus.fast_watch = ~bus.fast_watch;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
